// File: rtl/router_pkg.sv
// router_pkg -- shared definitions for the 1xN packet router.
//   state_t        : write-side FSM states
//   HDR_*          : header field positions and widths ({len, addr})
//   DEF_*          : default values for the router parameters
//   hdr_addr/len   : header field extraction helpers
package router_pkg;

   typedef enum logic [2:0] {
      DECODE,
      WAIT_EMPTY,
      LOAD_DATA,
      CHECK_PARITY,
      DROP
   } state_t;

   localparam int HDR_ADDR_LSB = 0;
   localparam int HDR_ADDR_W   = 2;
   localparam int HDR_LEN_LSB  = 2;
   localparam int HDR_LEN_W    = 6;

   localparam int DEF_NUM_PORTS  = 3;
   localparam int DEF_FIFO_DEPTH = 16;
   localparam int DEF_TIMEOUT    = 30;

   function automatic logic [HDR_ADDR_W-1:0] hdr_addr(input logic [7:0] hdr);
      return hdr[HDR_ADDR_LSB +: HDR_ADDR_W];
   endfunction

   function automatic logic [HDR_LEN_W-1:0] hdr_len(input logic [7:0] hdr);
      return hdr[HDR_LEN_LSB +: HDR_LEN_W];
   endfunction

endpackage

// File: rtl/router_fifo.sv
// router_fifo -- byte FIFO for one router output port.
// Ports:
//   clock, resetn    : rising-edge clock, synchronous active-low reset
//   flush            : empties the FIFO on the next edge (wins over rd/wr)
//   wr_en, wr_data   : write request and byte; ignored while full
//   rd_en, rd_data   : read request; head byte registered onto rd_data,
//                      ignored while empty (rd_data then holds)
//   empty, full      : occupancy flags
module router_fifo #(
   parameter int DEPTH = 16
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       flush,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   input  logic       rd_en,
   output logic [7:0] rd_data,
   output logic       empty,
   output logic       full
);

   localparam int AW = $clog2(DEPTH);

   // Extra MSB on each pointer distinguishes full from empty without a spare slot.
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [7:0]  mem [DEPTH];
   logic        wr_ok;
   logic        rd_ok;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign wr_ok = wr_en && !full && !flush;
   assign rd_ok = rd_en && !empty && !flush;

   always_ff @(posedge clock) begin
      if (!resetn) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         rd_data <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) begin
            rd_data <= mem[rd_ptr[AW-1:0]];
            rd_ptr  <= rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (resetn && wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/router_1xn.sv
// router_1xn -- routes byte packets {hdr, payload..., parity} from one input
// to one of NUM_PORTS output FIFOs selected by the header address.
// Ports:
//   clock, resetn : rising-edge clock, synchronous active-low reset
//   data_in       : header, payload or parity byte
//   pkt_valid     : high for header/payload, low for the parity byte
//   read_enb      : per-port read request
//   data_out      : per-port registered byte, port k at [8k+7:8k]
//   valid_out     : per-port FIFO not empty
//   busy          : input byte not accepted this cycle
//   error         : parity mismatch on the last packet
//   drop          : one-cycle pulse when an invalid-address packet is discarded
// Optional feature: define ROUTER_SOFT_RESET_EN to flush a port whose data
// sits unread for TIMEOUT cycles.
//
// state        | meaning
// DECODE       | idle, header accepted when pkt_valid=1
// WAIT_EMPTY   | header held until the target FIFO drains
// LOAD_DATA    | payload/parity bytes written, stalls while FIFO full
// CHECK_PARITY | one cycle to register the parity result
// DROP         | bytes of an invalid-address packet discarded
module router_1xn
   import router_pkg::*;
#(
   parameter int NUM_PORTS  = DEF_NUM_PORTS,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic                   clock,
   input  logic                   resetn,
   input  logic [7:0]             data_in,
   input  logic                   pkt_valid,
   input  logic [NUM_PORTS-1:0]   read_enb,
   output logic [8*NUM_PORTS-1:0] data_out,
   output logic [NUM_PORTS-1:0]   valid_out,
   output logic                   busy,
   output logic                   error,
   output logic                   drop
);

   state_t         state_q, state_d;
   logic [1:0]     addr_q;
   logic [7:0]     hdr_q;
   logic [7:0]     parity_q;
   logic [7:0]     rx_par_q;
   logic [1:0]     hdr_addr_in;
   logic           addr_bad;
   logic [NUM_PORTS-1:0] empty, full, flush, wr_en;
   // Padded to the full 2-bit address space so any address indexes safely.
   logic [3:0]     empty_all, full_all;
   logic           wr_go;
   logic [1:0]     wr_addr;
   logic [7:0]     wr_data;
   logic           hdr_take, par_take, last_take, drop_d;

   assign hdr_addr_in = hdr_addr(data_in);
   assign addr_bad    = ({1'b0, hdr_addr_in} >= 3'(NUM_PORTS));
   assign valid_out   = ~empty;

   always_comb begin
      empty_all = '1;
      full_all  = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         empty_all[k] = empty[k];
         full_all[k]  = full[k];
      end
   end

`ifdef ROUTER_SOFT_RESET_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] idle_cnt [NUM_PORTS];
   logic          flush_cur;

   for (genvar k = 0; k < NUM_PORTS; k++) begin : g_idle
      assign flush[k] = (idle_cnt[k] == TW'(TIMEOUT));
      always_ff @(posedge clock) begin
         if (!resetn)                         idle_cnt[k] <= '0;
         else if (flush[k])                   idle_cnt[k] <= '0;
         else if (valid_out[k] && !read_enb[k]) idle_cnt[k] <= idle_cnt[k] + 1'b1;
         else                                 idle_cnt[k] <= '0;
      end
   end

   always_comb begin
      flush_cur = 1'b0;
      for (int k = 0; k < NUM_PORTS; k++)
         if (addr_q == 2'(k)) flush_cur = flush[k];
   end
`else
   localparam int timeout_unused = TIMEOUT;
   assign flush = '0;
`endif

   always_comb begin
      state_d   = state_q;
      busy      = 1'b0;
      wr_go     = 1'b0;
      wr_addr   = addr_q;
      wr_data   = data_in;
      hdr_take  = 1'b0;
      par_take  = 1'b0;
      last_take = 1'b0;
      drop_d    = 1'b0;
      case (state_q)
         DECODE: begin
            if (pkt_valid) begin
               hdr_take = 1'b1;
               if (addr_bad) begin
                  state_d = DROP;
               end else if (empty_all[hdr_addr_in]) begin
                  wr_go   = 1'b1;
                  wr_addr = hdr_addr_in;
                  state_d = LOAD_DATA;
               end else begin
                  state_d = WAIT_EMPTY;
               end
            end
         end
         WAIT_EMPTY: begin
            busy = 1'b1;
            if (empty_all[addr_q]) begin
               wr_go   = 1'b1;
               wr_data = hdr_q;
               state_d = LOAD_DATA;
            end
         end
         LOAD_DATA: begin
            busy = full_all[addr_q];
            if (!full_all[addr_q]) begin
               wr_go = 1'b1;
               if (pkt_valid) begin
                  par_take = 1'b1;
               end else begin
                  last_take = 1'b1;
                  state_d   = CHECK_PARITY;
               end
            end
         end
         CHECK_PARITY: begin
            busy    = 1'b1;
            state_d = DECODE;
         end
         DROP: begin
            if (!pkt_valid) begin
               drop_d  = 1'b1;
               state_d = DECODE;
            end
         end
         default: state_d = DECODE;
      endcase
`ifdef ROUTER_SOFT_RESET_EN
      // Target port flushed under a packet in flight: discard the rest.
      // If this cycle already consumes the parity byte, the packet ends here.
      if (state_q == LOAD_DATA && flush_cur) begin
         wr_go     = 1'b0;
         par_take  = 1'b0;
         last_take = 1'b0;
         if (!busy && !pkt_valid) begin
            drop_d  = 1'b1;
            state_d = DECODE;
         end else begin
            state_d = DROP;
         end
      end
`endif
   end

   for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
      assign wr_en[k] = wr_go && (wr_addr == 2'(k));
      router_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
         .clock   (clock),
         .resetn  (resetn),
         .flush   (flush[k]),
         .wr_en   (wr_en[k]),
         .wr_data (wr_data),
         .rd_en   (read_enb[k]),
         .rd_data (data_out[8*k +: 8]),
         .empty   (empty[k]),
         .full    (full[k])
      );
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q  <= DECODE;
         addr_q   <= '0;
         hdr_q    <= '0;
         parity_q <= '0;
         rx_par_q <= '0;
         error    <= 1'b0;
         drop     <= 1'b0;
      end else begin
         state_q <= state_d;
         drop    <= drop_d;
         if (hdr_take) begin
            hdr_q    <= data_in;
            addr_q   <= hdr_addr_in;
            parity_q <= data_in;
            error    <= 1'b0;
         end
         if (par_take)  parity_q <= parity_q ^ data_in;
         if (last_take) rx_par_q <= data_in;
         if (state_q == CHECK_PARITY) error <= (parity_q != rx_par_q);
      end
   end

endmodule

// File: tb/tb_router_1xn.sv
// tb_router_1xn -- scoreboard bench for router_1xn. Senders push expected
// bytes per port; a monitor pops and compares every registered read.
module tb_router_1xn;

   localparam int NP    = 3;
   localparam int DEPTH = 16;
   localparam int TO    = 30;

   logic            clock = 1'b0;
   logic            resetn;
   logic [7:0]      data_in;
   logic            pkt_valid;
   logic [NP-1:0]   read_enb;
   logic [8*NP-1:0] data_out;
   logic [NP-1:0]   valid_out;
   logic            busy, error, drop;

   always #5 clock = ~clock;

   router_1xn #(.NUM_PORTS(NP), .FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
      .clock     (clock),
      .resetn    (resetn),
      .data_in   (data_in),
      .pkt_valid (pkt_valid),
      .read_enb  (read_enb),
      .data_out  (data_out),
      .valid_out (valid_out),
      .busy      (busy),
      .error     (error),
      .drop      (drop)
   );

   int n_chk  = 0;
   int n_fail = 0;
   logic [7:0] q0[$], q1[$], q2[$];

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   task automatic push_exp(input int p, input logic [7:0] b);
      case (p)
         0: q0.push_back(b);
         1: q1.push_back(b);
         2: q2.push_back(b);
         default: ;
      endcase
   endtask

   // Monitor: a read fired before edge N shows on data_out after edge N.
   logic [NP-1:0] pend = '0;
   logic [7:0]    mon_exp;
   bit            mon_have;
   always @(negedge clock) begin
      for (int k = 0; k < NP; k++) begin
         if (pend[k]) begin
            mon_have = 1'b0;
            mon_exp  = '0;
            case (k)
               0: if (q0.size() > 0) begin mon_have = 1'b1; mon_exp = q0.pop_front(); end
               1: if (q1.size() > 0) begin mon_have = 1'b1; mon_exp = q1.pop_front(); end
               2: if (q2.size() > 0) begin mon_have = 1'b1; mon_exp = q2.pop_front(); end
               default: ;
            endcase
            if (!mon_have) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_read port%0d: got %0h expected none", k, data_out[8*k +: 8]);
            end else begin
               check($sformatf("rd_port%0d", k), 32'(data_out[8*k +: 8]), 32'(mon_exp));
            end
         end
      end
      pend = resetn ? (read_enb & valid_out) : '0;
   end

   // Present a byte and hold it until the router accepts it.
   task automatic put_byte(input logic [7:0] d, input logic v, output int stalls);
      bit acc;
      stalls    = 0;
      data_in   = d;
      pkt_valid = v;
      for (int n = 0; n < 300; n++) begin
         @(negedge clock);
         acc = !busy;
         @(posedge clock);
         #1;
         if (acc) return;
         stalls++;
      end
      check("accept_timeout", 32'(stalls), 32'(0));
   endtask

   task automatic send_pkt(input int p, input int len, input bit bad, input int rd_after,
                           output int stalls, output logic err_h);
      logic [7:0] hdr, par, b;
      int s;
      hdr    = {len[5:0], p[1:0]};
      par    = hdr;
      stalls = 0;
      push_exp(p, hdr);
      put_byte(hdr, 1'b1, s);
      err_h = error;
      for (int i = 1; i <= len; i++) begin
         b   = 8'(i * 7 + p * 16 + 8'h11);
         par = par ^ b;
         push_exp(p, b);
         put_byte(b, 1'b1, s);
         stalls += s;
         if (i == rd_after) begin
            repeat (3) begin
               @(negedge clock);
               check("full_busy", 32'(busy), 32'(1));
            end
            @(posedge clock);
            #1;
            read_enb[p] = 1'b1;
         end
      end
      b = bad ? ~par : par;
      push_exp(p, b);
      put_byte(b, 1'b0, s);
      stalls   += s;
      pkt_valid = 1'b0;
      data_in   = 8'h00;
   endtask

   task automatic wait_drain(input int p);
      int n;
      n = 0;
      while ((valid_out[p] || pend[p]) && n < 300) begin
         @(posedge clock);
         #1;
         n++;
      end
      check($sformatf("drain_port%0d", p), 32'(valid_out[p]), 32'(0));
   endtask

   int   st, st2, cnt;
   logic eh, eh2;

   initial begin
      resetn    = 1'b0;
      data_in   = '0;
      pkt_valid = 1'b0;
      read_enb  = '0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_valid_out", 32'(valid_out), 32'(0));
      check("rst_data_out",  32'(data_out),  32'(0));
      check("rst_busy",      32'(busy),      32'(0));
      check("rst_error",     32'(error),     32'(0));
      check("rst_drop",      32'(drop),      32'(0));
      resetn = 1'b1;
      @(posedge clock);
      #1;

      // len=12 to port 1 with continuous reads: never stalls on payload
      read_enb = 3'b011;
      send_pkt(1, 12, 1'b0, -1, st, eh);
      check("len12_stalls", 32'(st), 32'(0));
      @(posedge clock);
      #1;
      check("len12_error", 32'(error), 32'(0));

      // corrupted parity: error after CHECK_PARITY, cleared by next header
      send_pkt(1, 5, 1'b1, -1, st, eh);
      check("err_early", 32'(error), 32'(0));
      @(posedge clock);
      #1;
      check("err_set", 32'(error), 32'(1));
      send_pkt(1, 2, 1'b0, -1, st, eh);
      check("err_clear_on_hdr", 32'(eh), 32'(0));
      @(posedge clock);
      #1;
      check("err_good_pkt", 32'(error), 32'(0));

      // len=35, no reads until byte 15 fills the FIFO
      wait_drain(1);
      read_enb[1] = 1'b0;
      send_pkt(1, 35, 1'b0, 15, st, eh);
      read_enb = 3'b011;

      // invalid address 3: dropped, nothing written
      wait_drain(1);
      wait_drain(0);
      send_pkt(3, 2, 1'b0, -1, st, eh);
      check("drop_pulse",   32'(drop),      32'(1));
      check("drop_nowrite", 32'(valid_out), 32'(0));
      check("drop_stalls",  32'(st),        32'(0));
      @(posedge clock);
      #1;
      check("drop_clear", 32'(drop), 32'(0));
      send_pkt(0, 4, 1'b0, -1, st, eh);
      wait_drain(0);

      // second packet to a non-empty port waits in WAIT_EMPTY
      read_enb = 3'b011;
      send_pkt(2, 3, 1'b0, -1, st, eh);
      fork
         send_pkt(2, 2, 1'b0, -1, st2, eh2);
         begin
            repeat (4) @(negedge clock);
            repeat (4) begin
               @(negedge clock);
               check("wait_busy", 32'(busy), 32'(1));
            end
            check("wait_port_full", 32'(valid_out[2]), 32'(1));
            @(posedge clock);
            #1;
            read_enb[2] = 1'b1;
         end
      join
      wait_drain(2);

      // reset mid-packet abandons it; a fresh packet then goes through
      read_enb = '0;
      put_byte({6'd6, 2'd0}, 1'b1, st);
      put_byte(8'hAA, 1'b1, st);
      resetn    = 1'b0;
      pkt_valid = 1'b0;
      @(posedge clock);
      #1;
      check("midrst_valid", 32'(valid_out), 32'(0));
      check("midrst_busy",  32'(busy),      32'(0));
      resetn   = 1'b1;
      read_enb = 3'b111;
      send_pkt(0, 1, 1'b0, -1, st, eh);
      wait_drain(0);

`ifdef ROUTER_SOFT_RESET_EN
      // unread port 2 is flushed TIMEOUT+1 cycles after valid_out rises
      read_enb = '0;
      fork
         send_pkt(2, 3, 1'b0, -1, st, eh);
         begin
            cnt = 0;
            while (!valid_out[2] && cnt < 200) begin
               @(negedge clock);
               cnt++;
            end
            cnt = 0;
            while (valid_out[2] && cnt < 200) begin
               cnt++;
               @(negedge clock);
            end
            check("timeout_fall", 32'(cnt), 32'(TO + 1));
         end
      join
      q2.delete();
`endif

      read_enb = 3'b111;
      cnt = 0;
      while ((q0.size() + q1.size() + q2.size()) != 0 && cnt < 500) begin
         @(posedge clock);
         #1;
         cnt++;
      end
      check("left_q0", 32'(q0.size()), 32'(0));
      check("left_q1", 32'(q1.size()), 32'(0));
      check("left_q2", 32'(q2.size()), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
